// File: rtl/aes_key_schedule_seq_if.sv
// Request/response bundle for the key-schedule block: expansion control
// plus the registered round-key read port.
interface aes_key_schedule_seq_if #(parameter int MAX_NK = 8);
  logic                  start;
  logic [1:0]            key_len;
  logic [32*MAX_NK-1:0]  key;
  logic                  busy;
  logic                  done;
  logic                  ready;
  logic                  cfg_err;
  logic                  rd_en;
  logic [3:0]            rd_round;
  logic                  rd_valid;
  logic [127:0]          rd_key;
  logic                  rd_err;

  modport master (
    output start, key_len, key, rd_en, rd_round,
    input  busy, done, ready, cfg_err, rd_valid, rd_key, rd_err
  );

  modport slave (
    input  start, key_len, key, rd_en, rd_round,
    output busy, done, ready, cfg_err, rd_valid, rd_key, rd_err
  );
endinterface

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128/192/256 key expander: one word per clock through a
// single shared 4-byte S-box row, results held in a word buffer that is
// read one round key at a time with 1-cycle latency.
module aes_key_schedule_seq #(
  parameter int MAX_NK = 8
) (
  input logic             clk,
  input logic             rst_n,
  aes_key_schedule_seq_if.slave bus
);
  localparam int BUF_W = 4 * (MAX_NK + 7);
  localparam int AW    = $clog2(BUF_W);

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND} state_t;

  state_t                      state, state_nxt;
  logic [1:0]                  klen_q;
  logic [MAX_NK-1:0][31:0]     key_q;      // word 0 is the most significant
  logic [31:0]                 w_buf [BUF_W];
  logic [AW-1:0]               idx;
  logic [2:0]                  kcnt;       // i mod Nk
  logic [7:0]                  rcon;
  logic [3:0]                  nr_done;    // Nr of the last completed schedule
  logic [3:0]                  nk, nr;
  logic [AW-1:0]               last_idx;
  logic                        accept, bad, last;
  logic [31:0]                 prev, back, sub_in, sub_out, temp, w_new;
  logic [AW-1:0]               rd_base;

  // Key-length decode from the captured configuration
  always_comb begin
    nk = 4'd4;
    nr = 4'd10;
    case (klen_q)
      2'b01:   begin nk = 4'd6; nr = 4'd12; end
      2'b10:   begin nk = 4'd8; nr = 4'd14; end
      default: begin nk = 4'd4; nr = 4'd10; end
    endcase
    last_idx = AW'({nr, 2'b11});   // W-1 = 4*Nr+3
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state and control strobes
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    bad       = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        accept = bus.start && (bus.key_len != 2'b11);
        bad    = bus.start && (bus.key_len == 2'b11);
        if (accept) state_nxt = LOAD;
      end
      LOAD:    state_nxt = EXPAND;
      EXPAND: begin
        last = (idx == last_idx);
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Next schedule word: the shared S-box row sees RotWord(w[i-1]) at the
  // start of each Nk group and plain w[i-1] otherwise.
  always_comb begin
    prev    = w_buf[idx - AW'(1)];
    back    = w_buf[idx - AW'(nk)];
    sub_in  = (kcnt == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    sub_out = {SBOX[sub_in[31:24]], SBOX[sub_in[23:16]],
               SBOX[sub_in[15:8]],  SBOX[sub_in[7:0]]};
    if (kcnt == 3'd0)                       temp = sub_out ^ {rcon, 24'h0};
    else if (nk == 4'd8 && kcnt == 3'd4)    temp = sub_out;
    else                                    temp = prev;
    w_new   = back ^ temp;
  end

  // Control/status registers and expansion counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      klen_q   <= 2'b00;
      key_q    <= '0;
      idx      <= '0;
      kcnt     <= '0;
      rcon     <= 8'h01;
      nr_done  <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.ready   <= 1'b0;
      bus.cfg_err <= 1'b0;
    end else begin
      bus.done    <= last;
      bus.cfg_err <= bad;
      bus.busy    <= (state_nxt != IDLE);
      if (accept) begin
        klen_q    <= bus.key_len;
        key_q     <= bus.key;
        bus.ready <= 1'b0;
        rcon      <= 8'h01;
      end
      if (state == LOAD) begin
        idx  <= AW'(nk);
        kcnt <= 3'd0;
      end
      if (state == EXPAND) begin
        idx  <= idx + AW'(1);
        kcnt <= ({1'b0, kcnt} == nk - 4'd1) ? 3'd0 : kcnt + 3'd1;
        if (kcnt == 3'd0) rcon <= xtime(rcon);
      end
      if (last) begin
        bus.ready <= 1'b1;
        nr_done   <= nr;
      end
    end
  end

  // Word buffer: whole key in LOAD, one expanded word per EXPAND cycle
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      for (int j = 0; j < MAX_NK; j++)
        if (j < int'(nk)) w_buf[j] <= key_q[MAX_NK-1-j];
    end else if (state == EXPAND) begin
      w_buf[idx] <= w_new;
    end
  end

  assign rd_base = AW'({bus.rd_round, 2'b00});

  // Registered round-key read; rejected reads return zero with rd_err
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rd_valid <= 1'b0;
      bus.rd_err   <= 1'b0;
      bus.rd_key   <= '0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en && bus.ready && (bus.rd_round <= nr_done)) begin
        bus.rd_err <= 1'b0;
        bus.rd_key <= {w_buf[rd_base], w_buf[rd_base + AW'(1)],
                       w_buf[rd_base + AW'(2)], w_buf[rd_base + AW'(3)]};
      end else begin
        bus.rd_err <= bus.rd_en;
        bus.rd_key <= '0;
      end
    end
  end
endmodule

// File: doc/aes_key_schedule_seq.md
# aes_key_schedule_seq

Sequential, multi-mode AES key schedule for the sender datapath. It accepts a 128-, 192- or 256-bit cipher key and expands it into the full round-key set, one 32-bit word per clock. The words are stored in an internal buffer that the round engine reads through a registered port. It is the clocked, key-length-generalised successor of the purely combinational AES-256 expander: one shared S-box row replaces the unrolled full-schedule logic.

## Interface
- `MAX_NK`, default 8: largest supported key length in words; sizes the key port (32·MAX_NK) and the buffer (4·(MAX_NK+7) words, 60 at the default).
- `clk`: input, 1 bit. Single clock, rising edge.
- `rst_n`: input, 1 bit. Reset is asynchronous and active-low.
- `start`: input, 1 bit. Expansion request, one-cycle pulse; accepted only while `busy`=0.
- `key_len`: input, 2 bits. 00 = AES-128, 01 = AES-192, 10 = AES-256, 11 = reserved.
- `key`: input, 32·MAX_NK bits. Key, left-aligned. AES-128 uses `key[255:128]`; AES-192 uses `key[255:64]`.
- `busy`: output, 1 bit. High from the cycle after `start` is accepted until the last word is written.
- `done`: output, 1 bit. One-cycle pulse when expansion completes.
- `ready`: output, 1 bit. Level: a complete schedule is held in the buffer.
- `cfg_err`: output, 1 bit. One-cycle pulse when `start` arrives with `key_len`=11.
- `rd_en`: input, 1 bit. Round-key read strobe.
- `rd_round`: input, 4 bits. Round index to read.
- `rd_valid`: output, 1 bit. Read response strobe.
- `rd_key`: output, 128 bits. `{w[4r], w[4r+1], w[4r+2], w[4r+3]}` for r = `rd_round`.
- `rd_err`: output, 1 bit. Read rejected.

## Operation
- Derived values: Nk = 4/6/8 and Nr = 10/12/14; total words W = 4·(Nr+1) = 44/52/60.
- FSM states: IDLE, LOAD, EXPAND.
- **IDLE → LOAD** on `start` with a valid `key_len`:
  - capture `key` and `key_len`;
  - clear `ready`;
  - set `busy`;
  - set rcon = 0x01.
- **`start` with `key_len`=11:** pulse `cfg_err`; the FSM stays in IDLE; `ready` and the buffer are unchanged.
- **LOAD:** write w[0..Nk-1] from the captured key in a single cycle; set i = Nk; go to EXPAND.
- **EXPAND:** each cycle compute and write word i:
  - temp = w[i-1];
  - if i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon = xtime(rcon), where xtime = shift left with conditional ^ 0x1b;
  - else if Nk == 8 and i mod Nk == 4: temp = SubWord(temp);
  - w[i] = w[i-Nk] ^ temp;
  - i mod Nk is tracked with a wrap counter (0..Nk-1), not a divider.
- **Completion:** when i == W-1 is written: go to IDLE, drop `busy`, pulse `done`, set `ready`.
- **`start` while `busy`:** ignored, no error.
- **`start` while `ready`:** accepted. `ready` drops and the buffer is overwritten.
- **Reads:**
  - accepted in any state;
  - if `rd_round` > Nr of the last *completed* schedule, or `ready`=0: `rd_err`=1 and `rd_key`=0;
  - otherwise `rd_key` = buffer contents.
- **Reset:** an asynchronous `rst_n` low at any time, including mid-EXPAND, forces:
  - state IDLE;
  - `busy`, `done`, `ready`, `cfg_err`, `rd_valid`, `rd_err` = 0;
  - `rd_key` = 0;
  - rcon = 0x01.
  Buffer contents need not be cleared; `ready`=0 masks them.

## Timing
- `start` is sampled at edge E0.
- E1: initial key words are written (LOAD).
- Word i (i ≥ Nk) is written at edge E(i−Nk+2).
- The last word is written at E41 (AES-128), E47 (AES-192) or E53 (AES-256). The same edge asserts `done` and `ready` and deasserts `busy`.
- `busy` is high in the cycles after E0 through the last write.
- Reads have 1-cycle latency: `rd_en` sampled at edge E drives `rd_valid` plus `rd_key`/`rd_err` after E, for one cycle. Back-to-back reads are allowed every cycle.
- `cfg_err` is asserted after the edge that samples the bad `start`, for one cycle.

## Test plan
- **AES-128 (FIPS-197 A.1):** key 2b7e1516 28aed2a6 abf71588 09cf4f3c → `done` at E41; round 10 reads d014f9a8c9ee2589e13f0cc8b6630ca6; round 0 reads the key.
- **AES-192 (FIPS-197 A.2):** key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b → `done` at E47; round 12 reads e98ba06f448c773c8ecc720401002202.
- **AES-256 (FIPS-197 A.3):** key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 → `done` at E53; round 14 reads fe4890d1e6188d0b046df344706c631e.
- **Bad reads and bad config:**
  - after the AES-128 run, read round 11 → `rd_err`=1, `rd_key`=0;
  - `start` with `key_len`=11 → `cfg_err` pulse, `ready` stays 1.
- **`start` during `busy`:** second `start` at E10 is ignored; `done` arrives only at the original edge and the results are unchanged.
- **Mid-run reset:** `rst_n` low at E20 of an AES-256 run → all outputs 0 immediately. A fresh AES-128 run then completes correctly, with the first rcon = 0x01.
